sig_pulse_meter: RTL

Downstream measurement stage for the `myprotocol` waveform generator. It samples the generator's `sig1`/`sig2`/`sig3` outputs on the system clock and measures three values: the `sig1` period, the `sig1` high width, and the `sig2`-rise lag relative to the `sig1` rise, all in clock cycles. Results are published with a one-cycle valid strobe, so benches and later stages can check generated waveforms without reading generator internals.

---
 rtl/sig_pulse_meter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sig_pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module   : sig_pulse_meter
//  Purpose  : Measures sig1 period, sig1 high width and sig2-rise lag (in clk
//             cycles) while the sig3 gate is high; publishes results with a
//             one-cycle meas_valid strobe.
//  Options  : PULSE_METER_SYNC_EN - 2-flop synchronizer on sig1/sig2/sig3
//             (otherwise a single sampling register, one cycle less latency).
//  Revision : 1.0 - initial release
// ============================================================================
module sig_pulse_meter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig1,
    input  logic             sig2,
    input  logic             sig3,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_w,
    output logic [CNT_W-1:0] lag,
    output logic             lag_valid,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             sat_err
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    // Sampled inputs, bit order {sig3, sig2, sig1}
    logic [2:0] r_samp;

`ifdef PULSE_METER_SYNC_EN
    logic [2:0] r_meta;

    // Two-flop synchronizer for sources not launched on the rising clk edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= '0;
            r_samp <= '0;
        end else begin
            r_meta <= {sig3, sig2, sig1};
            r_samp <= r_meta;
        end
    end
`else
    // Single sampling register; inputs are assumed synchronous to clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_samp <= '0;
        end else begin
            r_samp <= {sig3, sig2, sig1};
        end
    end
`endif

    logic w_s1, w_s2, w_s3;
    logic r_s1_d, r_s2_d;
    logic w_r1, w_f1, w_r2;

    assign w_s1 = r_samp[0];
    assign w_s2 = r_samp[1];
    assign w_s3 = r_samp[2];

    // One delay register per waveform for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_d <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1_d <= w_s1;
            r_s2_d <= w_s2;
        end
    end

    assign w_r1 = w_s1 & ~r_s1_d;
    assign w_f1 = ~w_s1 & r_s1_d;
    assign w_r2 = w_s2 & ~r_s2_d;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hw_tmp;
    logic [CNT_W-1:0] r_lag_tmp;
    logic             r_flag;
    logic             r_meas_valid;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_w;
    logic [CNT_W-1:0] r_lag;
    logic             r_lag_valid;
    logic [CNT_W-1:0] r_meas_cnt;
    logic             r_sat_err;

    // Measurement FSM: cycle counter, per-period captures and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_hw_tmp     <= '0;
            r_lag_tmp    <= '0;
            r_flag       <= 1'b0;
            r_meas_valid <= 1'b0;
            r_period     <= '0;
            r_high_w     <= '0;
            r_lag        <= '0;
            r_lag_valid  <= 1'b0;
            r_meas_cnt   <= '0;
            r_sat_err    <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (!w_s3) begin
                // Gate closed: abandon any partial period
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_flag  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt   <= '0;
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_r1) begin
                            // First rise only opens a period; nothing to publish yet
                            r_cnt     <= C_CNT_ONE;
                            r_flag    <= w_r2;
                            r_lag_tmp <= '0;
                            r_state   <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (w_r1) begin
                            // Close the period (r1 wins over saturation) and reopen
                            r_period     <= r_cnt;
                            r_high_w     <= r_hw_tmp;
                            r_lag        <= r_lag_tmp;
                            r_lag_valid  <= r_flag;
                            r_meas_valid <= 1'b1;
                            r_meas_cnt   <= r_meas_cnt + C_CNT_ONE;
                            r_cnt        <= C_CNT_ONE;
                            r_flag       <= w_r2;
                            r_lag_tmp    <= '0;
                        end else if (r_cnt == C_CNT_MAX) begin
                            r_sat_err <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= ST_ARM;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                            if (w_f1) begin
                                r_hw_tmp <= r_cnt;
                            end
                            if (w_r2 && !r_flag) begin
                                r_lag_tmp <= r_cnt;
                                r_flag    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign meas_valid = r_meas_valid;
    assign period     = r_period;
    assign high_w     = r_high_w;
    assign lag        = r_lag;
    assign lag_valid  = r_lag_valid;
    assign meas_cnt   = r_meas_cnt;
    assign sat_err    = r_sat_err;

endmodule
`default_nettype wire
